seq_pattern_tx: RTL and testbench

Serial bit-pattern transmitter, the generating end of the team's serial sequence-detection path. It captures a WIDTH-bit pattern and a repeat count on a start/ready handshake. It then drives the pattern MSB-first onto a 1-bit serial line, one bit per clock, with optional idle gap cycles between repetitions. Its output feeds sequence-detector blocks directly, both in the design and in loopback benches.

---
 rtl/seq_tx_pkg.sv | 16 +
 rtl/seq_pattern_tx.sv | 153 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and default parameters for the serial pattern transmitter.
//   tx_state_t : transmitter FSM state (IDLE / SHIFT / GAP)
//   *_DEF      : default values for WIDTH, CNT_W and GAP
package seq_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_SHIFT = 2'b01,
        TX_GAP   = 2'b10
    } tx_state_t;

    localparam int unsigned WIDTH_DEF = 3;
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned GAP_DEF   = 1;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter. Captures a WIDTH-bit pattern and a repeat
// count on a start/ready handshake, then shifts the pattern out MSB-first,
// one bit per clock, repeating it with GAP idle cycles between frames.
//
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   pat        : pattern to send, MSB first
//   rep        : number of frames to send (0 is treated as 1)
//   start      : request, accepted when start && ready at a posedge
//   ready      : high only while idle
//   out        : serial data, 0 whenever out_valid is low
//   out_valid  : high on every pattern-bit cycle
//   frame_done : pulse on the last bit of each frame
//   all_done   : pulse on the last bit of the last frame
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pat,
    input  logic [CNT_W-1:0] rep,
    input  logic             start,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_done,
    output logic             all_done
);

    localparam int unsigned      IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             gap_last;

    logic ready_d, out_d, out_valid_d, frame_done_d, all_done_d;

    // Gap counter: counts cycles spent in TX_GAP, cleared everywhere else.
    if (GAP > 0) begin : g_gap
        localparam int unsigned GAP_W = $clog2(GAP + 1);
        logic [GAP_W-1:0] gap_cnt_q;

        always_ff @(posedge clk) begin
            if (rst || (state_q != TX_GAP)) begin
                gap_cnt_q <= '0;
            end else begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
        end

        assign gap_last = (gap_cnt_q == GAP_W'(GAP - 1));
    end else begin : g_no_gap
        assign gap_last = 1'b1;
    end

    // State and datapath registers, plus the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            shadow_q   <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
            ready      <= 1'b1;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            all_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            ready      <= ready_d;
            out        <= out_d;
            out_valid  <= out_valid_d;
            frame_done <= frame_done_d;
            all_done   <= all_done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d  = TX_SHIFT;
                    shadow_d = pat;
                    idx_d    = IDX_TOP;
                    rem_d    = (rep == '0) ? CNT_W'(1) : rep;
                end
            end
            TX_SHIFT: begin
                if (idx_q == '0) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = TX_IDLE;
                    end else if (GAP > 0) begin
                        state_d = TX_GAP;
                    end else begin
                        idx_d = IDX_TOP;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            TX_GAP: begin
                if (gap_last) begin
                    state_d = TX_SHIFT;
                    idx_d   = IDX_TOP;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        ready_d      = 1'b0;
        out_d        = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        all_done_d   = 1'b0;
        case (state_d)
            TX_SHIFT: begin
                out_d        = shadow_d[idx_d];
                out_valid_d  = 1'b1;
                frame_done_d = (idx_d == '0);
                // rem_d still counts the frame being sent at this point.
                all_done_d   = (idx_d == '0) && (rem_d == CNT_W'(1));
            end
            TX_GAP: begin
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx. Two instances share pat/rep/rst:
// dut0 with GAP=1 and dut1 with GAP=0. Expected per-cycle output streams are
// generated from the frame/gap rules by a small queue-based model.
module tb_seq_pattern_tx;

    localparam int W  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  pat;
    logic [CW-1:0] rep;
    logic          start0, start1;
    logic          ready0, out0, ov0, fd0, ad0;
    logic          ready1, out1, ov1, fd1, ad1;

    int checks = 0;
    int errors = 0;

    // Expected {ready, out, out_valid, frame_done, all_done} per cycle.
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(W), .CNT_W(CW), .GAP(1)) dut0 (
        .clk(clk), .rst(rst), .pat(pat), .rep(rep), .start(start0),
        .ready(ready0), .out(out0), .out_valid(ov0),
        .frame_done(fd0), .all_done(ad0)
    );

    seq_pattern_tx #(.WIDTH(W), .CNT_W(CW), .GAP(0)) dut1 (
        .clk(clk), .rst(rst), .pat(pat), .rep(rep), .start(start1),
        .ready(ready1), .out(out1), .out_valid(ov1),
        .frame_done(fd1), .all_done(ad1)
    );

    function automatic logic [4:0] obs(input int which);
        if (which == 0) return {ready0, out0, ov0, fd0, ad0};
        return {ready1, out1, ov1, fd1, ad1};
    endfunction

    task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (ready,out,valid,frame_done,all_done)",
                   tag, o, e);
        end
    endtask

    task automatic drive_start(input int which, input logic v);
        if (which == 0) start0 = v;
        else start1 = v;
    endtask

    // Busy stream: n frames of the pattern MSB-first, gap zeros between frames.
    task automatic build(input logic [W-1:0] p, input logic [CW-1:0] r, input int gap);
        int n;
        n = (r == 0) ? 1 : int'(r);
        exp_q.delete();
        for (int f = 0; f < n; f++) begin
            for (int b = W - 1; b >= 0; b--) begin
                exp_q.push_back({1'b0, p[b], 1'b1, (b == 0), (b == 0 && f == n - 1)});
            end
            if (f < n - 1) begin
                for (int g = 0; g < gap; g++) exp_q.push_back(5'b00000);
            end
        end
    endtask

    task automatic wait_ready(input int which);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (obs(which) === 5'b10000) seen = 1'b1;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL wait_ready observed=%b expected=10000", obs(which));
        end
    endtask

    // Drives start for exactly the accepting edge, then scrambles pat/rep.
    task automatic launch(input int which, input logic [W-1:0] p, input logic [CW-1:0] r);
        wait_ready(which);
        pat = p;
        rep = r;
        drive_start(which, 1'b1);
        @(posedge clk);
        #1;
        drive_start(which, 1'b0);
        pat = W'($urandom);
        rep = CW'($urandom);
    endtask

    // Checks exp_q cycle by cycle starting just after the accepting edge.
    // pulse_idx: cycle in which pat is zeroed and start pulsed (should be ignored).
    // hold_idx : cycle from which start is held high with a new job; left high on return.
    task automatic expect_stream(input int which, input string tag, input int pulse_idx,
                                 input int hold_idx, input logic [W-1:0] hold_p,
                                 input logic [CW-1:0] hold_r);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == pulse_idx) begin
                pat = '0;
                drive_start(which, 1'b1);
            end else if (i == pulse_idx + 1) begin
                drive_start(which, 1'b0);
            end
            if (i == hold_idx) begin
                pat = hold_p;
                rep = hold_r;
                drive_start(which, 1'b1);
            end
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), obs(which), exp_q[i]);
            @(posedge clk);
            #1;
        end
        if (hold_idx < 0) drive_start(which, 1'b0);
        @(negedge clk);
        check({tag, "_ready"}, obs(which), 5'b10000);
        if (hold_idx < 0) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check({tag, "_idle"}, obs(which), 5'b10000);
        end
    endtask

    initial begin
        int            which;
        logic [W-1:0]  p;
        logic [CW-1:0] r;

        rst    = 1'b1;
        start0 = 1'b1;
        start1 = 1'b1;
        pat    = 3'b111;
        rep    = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        check("reset0", obs(0), 5'b10000);
        check("reset1", obs(1), 5'b10000);
        rst = 1'b0;

        // Single frame, GAP=1.
        build(3'b101, 4'd1, 1);
        launch(0, 3'b101, 4'd1);
        expect_stream(0, "t1", -1, -1, '0, '0);

        // Three frames with gaps.
        build(3'b101, 4'd3, 1);
        launch(0, 3'b101, 4'd3);
        expect_stream(0, "t2", -1, -1, '0, '0);

        // Back-to-back frames, GAP=0.
        build(3'b110, 4'd2, 0);
        launch(1, 3'b110, 4'd2);
        expect_stream(1, "t3", -1, -1, '0, '0);

        // rep=0 sends one frame.
        build(3'b011, 4'd0, 1);
        launch(0, 3'b011, 4'd0);
        expect_stream(0, "t4", -1, -1, '0, '0);

        // Maximum repeat count must not wrap.
        build(3'b100, 4'd15, 0);
        launch(1, 3'b100, 4'd15);
        expect_stream(1, "tmax", -1, -1, '0, '0);

        // Reset asserted during cycle 5 of a rep=3 job.
        build(3'b101, 4'd3, 1);
        launch(0, 3'b101, 4'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t5[%0d]", i), obs(0), exp_q[i]);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("t5[4]", obs(0), exp_q[4]);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst", obs(0), 5'b10000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_rst_idle", obs(0), 5'b10000);
        build(3'b110, 4'd1, 1);
        launch(0, 3'b110, 4'd1);
        expect_stream(0, "t5_new", -1, -1, '0, '0);

        // Mid-frame pat change + ignored start, then start held across return to idle.
        build(3'b101, 4'd2, 1);
        launch(0, 3'b101, 4'd2);
        expect_stream(0, "t6", 1, 5, 3'b011, 4'd1);
        @(posedge clk);
        #1;
        drive_start(0, 1'b0);
        pat = W'($urandom);
        rep = CW'($urandom);
        build(3'b011, 4'd1, 1);
        expect_stream(0, "t6b", -1, -1, '0, '0);

        // Randomized jobs on either instance, with an ignored start pulse.
        for (int k = 0; k < 10; k++) begin
            which = int'($urandom_range(0, 1));
            p     = W'($urandom);
            r     = CW'($urandom_range(0, 5));
            build(p, r, (which == 0) ? 1 : 0);
            launch(which, p, r);
            expect_stream(which, $sformatf("rnd%0d", k),
                          int'($urandom_range(0, exp_q.size() - 1)), -1, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
